// File: rtl/led_fade_pwm.sv
`default_nettype none
// ============================================================================
// Module   : led_fade_pwm
// Brief    : Per-channel LED brightness fader with glitch-free shadowed PWM.
// Revision : 1.0 - initial release
// ============================================================================
module led_fade_pwm #(
    parameter int NUM_CH   = 5,
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 65536,
    parameter int STEP     = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ENABLE,
    input  logic [NUM_CH-1:0]          TARGET,
    output logic [NUM_CH-1:0]          LED_OUT,
    output logic [NUM_CH*PWM_BITS-1:0] LEVEL,
    output logic                       PERIOD_START
);

    localparam int                  PS_W      = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_BITS-1:0] c_LVL_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS:0]   c_STEP_W  = (PWM_BITS + 1)'(STEP);
    localparam logic [PS_W-1:0]     c_PS_LAST = PS_W'(FADE_DIV - 1);

    logic [PWM_BITS-1:0] r_pwm_cnt_q;
    logic [PS_W-1:0]     r_presc_q;
    logic [PS_W-1:0]     w_presc_d;
    logic                r_period_start_q;
    logic                w_fade_tick;
    logic                w_copy;

    assign w_fade_tick = ENABLE && (r_presc_q == c_PS_LAST);
    assign w_copy      = (r_pwm_cnt_q == c_LVL_MAX);

    // The prescaler only advances while enabled so a resumed fade continues where it paused.
    always_comb begin
        w_presc_d = r_presc_q;
        if (w_fade_tick) begin
            w_presc_d = '0;
        end else if (ENABLE) begin
            w_presc_d = r_presc_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pwm_cnt_q      <= '0;
            r_presc_q        <= '0;
            r_period_start_q <= 1'b0;
        end else begin
            r_pwm_cnt_q      <= r_pwm_cnt_q + 1'b1;
            r_presc_q        <= w_presc_d;
            r_period_start_q <= (r_pwm_cnt_q == '0);
        end
    end

    assign PERIOD_START = r_period_start_q;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [PWM_BITS-1:0] r_level_q;
            logic [PWM_BITS-1:0] w_level_d;
            logic [PWM_BITS-1:0] r_shadow_q;
            logic [PWM_BITS:0]   w_sum;
            logic                r_led_q;

            // One extra bit of headroom: a set carry means the ramp overshot full scale.
            assign w_sum = {1'b0, r_level_q} + c_STEP_W;

            always_comb begin
                w_level_d = r_level_q;
                if (w_fade_tick) begin
                    if (TARGET[gi]) begin
                        w_level_d = w_sum[PWM_BITS] ? c_LVL_MAX : w_sum[PWM_BITS-1:0];
                    end else if ({1'b0, r_level_q} >= c_STEP_W) begin
                        w_level_d = r_level_q - c_STEP_W[PWM_BITS-1:0];
                    end else begin
                        w_level_d = '0;
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_level_q  <= '0;
                    r_shadow_q <= '0;
                    r_led_q    <= 1'b0;
                end else begin
                    r_level_q <= w_level_d;
                    // Shadow takes the pre-tick level so duty only changes on a period boundary.
                    if (w_copy) begin
                        r_shadow_q <= r_level_q;
                    end
                    r_led_q <= ENABLE && ((r_shadow_q == c_LVL_MAX) || (r_pwm_cnt_q < r_shadow_q));
                end
            end

            assign LED_OUT[gi]                       = r_led_q;
            assign LEVEL[gi*PWM_BITS +: PWM_BITS]    = r_level_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_led_fade_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_fade_pwm
// Brief    : Randomized self-checking bench for led_fade_pwm (STEP 4 and 12).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_fade_pwm;

    localparam int NCH = 5;
    localparam int PB  = 4;
    localparam int FD  = 3;
    localparam int MX  = (1 << PB) - 1;
    localparam int VW  = NCH * PB + NCH + 1;

    logic clk, rst, en;
    logic [NCH-1:0]    target;
    logic [NCH-1:0]    led0, led1;
    logic [NCH*PB-1:0] level0, level1;
    logic              ps0, ps1;
    logic [VW-1:0]     obs0, obs1;

    int total = 0;
    int bad   = 0;

    // Behavioural model: time since reset, enabled-cycle count, per-channel integer levels.
    int m_cycles, m_en_cycles;
    int m_lvl [2][NCH];
    int m_shd [2][NCH];
    bit m_led [2][NCH];
    bit m_ps;

    led_fade_pwm #(.NUM_CH(NCH), .PWM_BITS(PB), .FADE_DIV(FD), .STEP(4)) u_dut0 (
        .CLK(clk), .RST(rst), .ENABLE(en), .TARGET(target),
        .LED_OUT(led0), .LEVEL(level0), .PERIOD_START(ps0)
    );

    led_fade_pwm #(.NUM_CH(NCH), .PWM_BITS(PB), .FADE_DIV(FD), .STEP(12)) u_dut1 (
        .CLK(clk), .RST(rst), .ENABLE(en), .TARGET(target),
        .LED_OUT(led1), .LEVEL(level1), .PERIOD_START(ps1)
    );

    assign obs0 = {level0, led0, ps0};
    assign obs1 = {level1, led1, ps1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int step_of(int d);
        return (d == 0) ? 4 : 12;
    endfunction

    function automatic logic [NCH*PB-1:0] lvl_vec(int d);
        logic [NCH*PB-1:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++) r[c*PB +: PB] = PB'(m_lvl[d][c]);
        return r;
    endfunction

    function automatic logic [VW-1:0] exp_vec(int d);
        logic [NCH-1:0] l;
        for (int c = 0; c < NCH; c++) l[c] = m_led[d][c];
        return {lvl_vec(d), l, m_ps};
    endfunction

    task automatic model_update();
        int  cnt;
        bit  tick;
        int  s;
        if (rst) begin
            m_cycles = 0; m_en_cycles = 0; m_ps = 1'b0;
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < NCH; c++) begin
                    m_lvl[d][c] = 0; m_shd[d][c] = 0; m_led[d][c] = 1'b0;
                end
        end else begin
            cnt  = m_cycles % (MX + 1);
            tick = en && ((m_en_cycles % FD) == FD - 1);
            for (int d = 0; d < 2; d++) begin
                s = step_of(d);
                for (int c = 0; c < NCH; c++) begin
                    m_led[d][c] = en && (m_shd[d][c] == MX || cnt < m_shd[d][c]);
                    if (cnt == MX) m_shd[d][c] = m_lvl[d][c];
                    if (tick) begin
                        if (target[c]) m_lvl[d][c] = (m_lvl[d][c] + s > MX) ? MX : m_lvl[d][c] + s;
                        else           m_lvl[d][c] = (m_lvl[d][c] >= s) ? m_lvl[d][c] - s : 0;
                    end
                end
            end
            m_ps = (cnt == 0);
            if (en) m_en_cycles++;
            m_cycles++;
        end
    endtask

    // Advance one clock: model steps on the active edge, outputs are observed on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        target = '1; en = 1'b1; rst = 1'b1;
        repeat (2) begin
            cycle();
            total++;
            if ({obs1, obs0} !== '0) begin
                bad++; $display("FAIL reset_zero got=%h/%h exp=0", obs0, obs1);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            total++;
            if (ps0 !== ((k % 16) == 1)) begin
                bad++; $display("FAIL period_start k=%0d got=%b exp=%b", k, ps0, (k % 16) == 1);
            end
            total++;
            if (obs1 !== exp_vec(1)) begin
                bad++; $display("FAIL reset_model_s12 got=%h exp=%h", obs1, exp_vec(1));
            end
        end
    endtask

    task automatic test_fade_up();
        int exp_seq [4] = '{4, 8, 12, 15};
        int seq [$];
        int last;
        rst = 1'b1; cycle(); rst = 1'b0;
        target = {NCH-1'(0), 1'b1} | (5'($urandom) & 5'b11110);
        en = 1'b1; last = 0;
        repeat (60) begin
            cycle();
            if (int'(level0[PB-1:0]) != last) begin
                last = int'(level0[PB-1:0]);
                seq.push_back(last);
            end
            total++;
            if (obs0 !== exp_vec(0)) begin
                bad++; $display("FAIL fade_up_s4 got=%h exp=%h", obs0, exp_vec(0));
            end
            total++;
            if (obs1 !== exp_vec(1)) begin
                bad++; $display("FAIL fade_up_s12 got=%h exp=%h", obs1, exp_vec(1));
            end
        end
        total++;
        if (seq.size() != 4 || seq[0] != exp_seq[0] || seq[1] != exp_seq[1] ||
            seq[2] != exp_seq[2] || seq[3] != exp_seq[3]) begin
            bad++; $display("FAIL fade_up_seq got=%p exp=%p", seq, exp_seq);
        end
    endtask

    task automatic test_fade_down();
        int exp0 [4] = '{11, 7, 3, 0};
        int exp1 [2] = '{3, 0};
        int s0 [$];
        int s1 [$];
        int l0, l1;
        target = 5'($urandom) & 5'b11110;
        l0 = MX; l1 = MX;
        repeat (40) begin
            cycle();
            if (int'(level0[PB-1:0]) != l0) begin l0 = int'(level0[PB-1:0]); s0.push_back(l0); end
            if (int'(level1[PB-1:0]) != l1) begin l1 = int'(level1[PB-1:0]); s1.push_back(l1); end
            total++;
            if (obs0 !== exp_vec(0)) begin
                bad++; $display("FAIL fade_down_s4 got=%h exp=%h", obs0, exp_vec(0));
            end
            total++;
            if (obs1 !== exp_vec(1)) begin
                bad++; $display("FAIL fade_down_s12 got=%h exp=%h", obs1, exp_vec(1));
            end
        end
        total++;
        if (s0.size() != 4 || s0[0] != exp0[0] || s0[1] != exp0[1] ||
            s0[2] != exp0[2] || s0[3] != exp0[3]) begin
            bad++; $display("FAIL fade_down_seq_s4 got=%p exp=%p", s0, exp0);
        end
        total++;
        if (s1.size() != 2 || s1[0] != exp1[0] || s1[1] != exp1[1]) begin
            bad++; $display("FAIL underflow_seq_s12 got=%p exp=%p", s1, exp1);
        end
    endtask

    task automatic test_duty();
        int  hi [2];
        int  want [2];
        bit  active;
        active = 1'b0; en = 1'b1;
        for (int k = 0; k < 96; k++) begin
            if (k % 8 == 0) target[1] = 1'($urandom);
            cycle();
            total++;
            if (obs0 !== exp_vec(0)) begin
                bad++; $display("FAIL duty_model_s4 got=%h exp=%h", obs0, exp_vec(0));
            end
            if (m_ps) begin
                if (active) begin
                    total++;
                    if (hi[0] != want[0] || hi[1] != want[1]) begin
                        bad++; $display("FAIL duty_ch1 got=%0d/%0d exp=%0d/%0d", hi[0], hi[1], want[0], want[1]);
                    end
                end
                active = 1'b1;
                for (int d = 0; d < 2; d++) begin
                    want[d] = (m_shd[d][1] == MX) ? MX + 1 : m_shd[d][1];
                    hi[d]   = 0;
                end
            end
            if (active) begin
                hi[0] += int'(led0[1]);
                hi[1] += int'(led1[1]);
            end
        end
    endtask

    task automatic test_enable_gating();
        logic [NCH*PB-1:0] held0;
        rst = 1'b1; cycle(); rst = 1'b0;
        en = 1'b1; target = 5'($urandom) | 5'b00001;
        repeat (7) cycle();
        en = 1'b0;
        held0 = lvl_vec(0);
        repeat (20) begin
            cycle();
            total++;
            if (led0 !== '0 || level0 !== held0) begin
                bad++; $display("FAIL gate_hold got=%h/%h exp=0/%h", led0, level0, held0);
            end
            total++;
            if (obs1 !== exp_vec(1)) begin
                bad++; $display("FAIL gate_model_s12 got=%h exp=%h", obs1, exp_vec(1));
            end
        end
        en = 1'b1;
        repeat (30) begin
            cycle();
            total++;
            if (obs0 !== exp_vec(0)) begin
                bad++; $display("FAIL gate_resume_s4 got=%h exp=%h", obs0, exp_vec(0));
            end
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        rst = 1'b1; cycle(); rst = 1'b0;
        target = '1; en = 1'b1; found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            cycle();
            total++;
            if (obs0 !== exp_vec(0)) begin
                bad++; $display("FAIL midrst_pre got=%h exp=%h", obs0, exp_vec(0));
            end
            found = (m_lvl[0][0] == 12) && ((m_cycles % (MX + 1)) == 9);
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL midrst_setup got=timeout exp=level12_cnt9");
        end
        rst = 1'b1; cycle(); rst = 1'b0;
        total++;
        if ({obs1, obs0} !== '0) begin
            bad++; $display("FAIL midrst_zero got=%h/%h exp=0", obs0, obs1);
        end
        for (int k = 1; k <= 4; k++) begin
            cycle();
            total++;
            if (level0[PB-1:0] !== PB'((k >= FD) ? 4 : 0) || level1[PB-1:0] !== PB'((k >= FD) ? 12 : 0)) begin
                bad++; $display("FAIL midrst_first_tick k=%0d got=%0d/%0d exp=%0d/%0d", k,
                    level0[PB-1:0], level1[PB-1:0], (k >= FD) ? 4 : 0, (k >= FD) ? 12 : 0);
            end
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            cycle();
            total++;
            if (obs0 !== exp_vec(0)) begin
                bad++; $display("FAIL random_s4 got=%h exp=%h", obs0, exp_vec(0));
            end
            total++;
            if (obs1 !== exp_vec(1)) begin
                bad++; $display("FAIL random_s12 got=%h exp=%h", obs1, exp_vec(1));
            end
            rst = ($urandom_range(99) == 0);
            en  = ($urandom_range(7) != 0);
            if ($urandom_range(3) == 0) target = 5'($urandom);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; target = '0;
        @(negedge clk);
        test_reset();
        test_fade_up();
        test_fade_down();
        test_duty();
        test_enable_gating();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
